// File: rtl/alu_multibank.sv
// Multi-channel ALU: per-channel command FIFOs feed one shared two-stage pipeline via a
// round-robin arbiter. Define ALU_SATURATE_EN to saturate OVERFLOW results instead of wrapping.
module alu_multibank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS-1:0]       i_cmd_valid,
  output logic [CHANNELS-1:0]       o_cmd_ready,
  input  logic [2*CHANNELS-1:0]     i_cmd_command,
  input  logic [WIDTH*CHANNELS-1:0] i_cmd_data1,
  input  logic [WIDTH*CHANNELS-1:0] i_cmd_data2,
  output logic [CHANNELS-1:0]       o_rsp_valid,
  input  logic [CHANNELS-1:0]       i_rsp_ready,
  output logic [2*CHANNELS-1:0]     o_rsp_response,
  output logic [WIDTH*CHANNELS-1:0] o_rsp_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_SHL  = 2'd3;
  localparam logic [1:0] RSP_NONE = 2'd0;
  localparam logic [1:0] RSP_OK   = 2'd1;
  localparam logic [1:0] RSP_OVF  = 2'd2;
  localparam logic [1:0] RSP_INV  = 2'd3;

  logic                r_alive;
  logic [CHANNELS-1:0] w_eligible;
  logic [1:0]          w_head_op [CHANNELS];
  logic [WIDTH-1:0]    w_head_a  [CHANNELS];
  logic [WIDTH-1:0]    w_head_b  [CHANNELS];

  logic                w_grant_valid;
  logic [CW-1:0]       w_grant_ch;
  logic [CW-1:0]       r_rr_ptr;

  logic                r_s1_valid;
  logic [CW-1:0]       r_s1_ch;
  logic [1:0]          r_s1_op;
  logic [WIDTH-1:0]    r_s1_a;
  logic [WIDTH-1:0]    r_s1_b;

  logic                r_s2_valid;
  logic [CW-1:0]       r_s2_ch;
  logic [1:0]          r_s2_resp;
  logic [WIDTH-1:0]    r_s2_data;

  logic [1:0]          w_alu_resp;
  logic [WIDTH-1:0]    w_alu_data;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_diff;
  logic [2*WIDTH-1:0]  w_shl;

  // Holds cmd_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_alive <= 1'b0;
    else          r_alive <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [1:0]       r_mem_op [DEPTH];
      logic [WIDTH-1:0] r_mem_a  [DEPTH];
      logic [WIDTH-1:0] r_mem_b  [DEPTH];
      logic [AW-1:0]    r_wr_ptr;
      logic [AW-1:0]    r_rd_ptr;
      logic [AW:0]      r_count;
      logic             r_busy;
      logic             r_rsp_valid;
      logic [1:0]       r_rsp_resp;
      logic [WIDTH-1:0] r_rsp_data;
      logic             w_push;
      logic             w_pop;
      logic             w_load;

      assign o_cmd_ready[gi] = r_alive & (r_count != (AW+1)'(DEPTH));
      assign w_push = i_cmd_valid[gi] & o_cmd_ready[gi] & (i_cmd_command[2*gi +: 2] != OP_NOP);
      assign w_pop  = w_grant_valid & (w_grant_ch == CW'(gi));
      assign w_load = r_s2_valid & (r_s2_ch == CW'(gi));
      // One op in flight per channel keeps its responses in submission order.
      assign w_eligible[gi] = (r_count != '0) & ~r_busy & (~r_rsp_valid | i_rsp_ready[gi]);

      assign w_head_op[gi] = r_mem_op[r_rd_ptr];
      assign w_head_a[gi]  = r_mem_a[r_rd_ptr];
      assign w_head_b[gi]  = r_mem_b[r_rd_ptr];

      always_ff @(posedge i_clk) begin
        if (w_push) begin
          r_mem_op[r_wr_ptr] <= i_cmd_command[2*gi +: 2];
          r_mem_a[r_wr_ptr]  <= i_cmd_data1[WIDTH*gi +: WIDTH];
          r_mem_b[r_wr_ptr]  <= i_cmd_data2[WIDTH*gi +: WIDTH];
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_wr_ptr    <= '0;
          r_rd_ptr    <= '0;
          r_count     <= '0;
          r_busy      <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_rsp_resp  <= RSP_NONE;
          r_rsp_data  <= '0;
        end else begin
          if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
          if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
          if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
          else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
          if (w_pop)       r_busy <= 1'b1;
          else if (w_load) r_busy <= 1'b0;
          if (w_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_resp  <= r_s2_resp;
            r_rsp_data  <= r_s2_data;
          end else if (r_rsp_valid && i_rsp_ready[gi]) begin
            r_rsp_valid <= 1'b0;
            r_rsp_resp  <= RSP_NONE;
            r_rsp_data  <= '0;
          end
        end
      end

      assign o_rsp_valid[gi]                = r_rsp_valid;
      assign o_rsp_response[2*gi +: 2]      = r_rsp_resp;
      assign o_rsp_data[WIDTH*gi +: WIDTH]  = r_rsp_data;
    end
  endgenerate

  // Round-robin: search begins at r_rr_ptr, which points one past the last grant.
  always_comb begin
    int            s;
    logic [CW-1:0] idx;
    w_grant_valid = 1'b0;
    w_grant_ch    = '0;
    s             = 0;
    idx           = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s = int'(r_rr_ptr) + i;
      if (s >= CHANNELS) s = s - CHANNELS;
      idx = CW'(s);
      if (!w_grant_valid && w_eligible[idx]) begin
        w_grant_valid = 1'b1;
        w_grant_ch    = idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_op    <= OP_NOP;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ch    <= '0;
      r_s2_resp  <= RSP_NONE;
      r_s2_data  <= '0;
    end else begin
      if (w_grant_valid) begin
        r_rr_ptr <= (w_grant_ch == CW'(CHANNELS-1)) ? '0 : w_grant_ch + CW'(1);
      end
      r_s1_valid <= w_grant_valid;
      r_s1_ch    <= w_grant_ch;
      r_s1_op    <= w_head_op[w_grant_ch];
      r_s1_a     <= w_head_a[w_grant_ch];
      r_s1_b     <= w_head_b[w_grant_ch];
      r_s2_valid <= r_s1_valid;
      r_s2_ch    <= r_s1_ch;
      r_s2_resp  <= w_alu_resp;
      r_s2_data  <= w_alu_data;
    end
  end

  always_comb begin
    w_sum      = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    w_diff     = {1'b0, r_s1_a} - {1'b0, r_s1_b};
    w_shl      = {{WIDTH{1'b0}}, r_s1_a} << r_s1_b;
    w_alu_resp = RSP_NONE;
    w_alu_data = '0;
    case (r_s1_op)
      OP_ADD: begin
        w_alu_resp = w_sum[WIDTH] ? RSP_OVF : RSP_OK;
        w_alu_data = w_sum[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (w_sum[WIDTH]) w_alu_data = '1;
`endif
      end
      OP_SUB: begin
        // Zero-extended subtraction: the top bit is the borrow.
        w_alu_resp = w_diff[WIDTH] ? RSP_OVF : RSP_OK;
        w_alu_data = w_diff[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        if (w_diff[WIDTH]) w_alu_data = '0;
`endif
      end
      OP_SHL: begin
        if (r_s1_b >= WIDTH'(WIDTH)) begin
          w_alu_resp = RSP_INV;
          w_alu_data = '0;
        end else begin
          w_alu_resp = (|w_shl[2*WIDTH-1:WIDTH]) ? RSP_OVF : RSP_OK;
          w_alu_data = w_shl[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
          if (|w_shl[2*WIDTH-1:WIDTH]) w_alu_data = '1;
`endif
        end
      end
      default: begin
        w_alu_resp = RSP_NONE;
        w_alu_data = '0;
      end
    endcase
  end

endmodule
